la_uart_tx_dump: RTL and testbench
==================================

Name: la_uart_tx_dump

Overview:
- Reads a captured logic-analyzer buffer out of a synchronous-read sample RAM and sends it byte by byte over a UART TX line, 8N1, LSB first.
- It is the transmit counterpart of the LA's UART receive capture path: the host requests a dump and this block streams buffer contents back.
- Sits beside the capture RAMs and drives their read-address port.
- Single clock domain, clk_50M.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; BAUD_DIV = CLK_FREQ / BAUD (integer division, 434 at defaults); must be >= 8
ADDR_W, 15, RAM address width
RAM_LAT, 1, RAM read latency in clocks (rd_data valid RAM_LAT clocks after rd_addr); RAM_LAT+2 < BAUD_DIV

Ports:
clk_50M  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle dump request, sampled only in IDLE
start_addr  in  ADDR_W  first RAM address to send, latched on accepted start
length  in  ADDR_W+1  byte count, latched on accepted start, 0..2^ADDR_W
abort  in  1  level; cancels the dump immediately
rd_addr  out  ADDR_W  RAM read address
rd_data  in  8  RAM read data
uart_tx  out  1  serial line, idle high
busy  out  1  high from the cycle after an accepted start until done or abort
done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async, rst_n=0): uart_tx=1, busy=0, done=0, rd_addr=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, FETCH, WAIT, START, DATA, STOP.
- IDLE:
  - start=1 with length!=0: latch start_addr into rd_addr and length into remaining; go to FETCH.
  - start=1 with length=0: send no frame; pulse done for one cycle on the next clock; busy stays 0.
- FETCH/WAIT: hold rd_addr for RAM_LAT clocks, then load rd_data into the 8-bit shift register and enter START.
  - uart_tx falls exactly RAM_LAT+2 clocks after the edge that samples start.
- Bit timing: baud counter runs 0..BAUD_DIV-1; every bit (START, 8 DATA, STOP) lasts exactly BAUD_DIV clocks.
- START drives 0. DATA sends shift[0] first, shifting right, 8 bits. STOP drives 1.
- Prefetch: on the first clock of STOP, rd_addr increments modulo 2^ADDR_W (0x7FFF wraps to 0x0000) and remaining decrements.
  - The next byte's rd_data is captured during STOP.
  - If remaining != 0 at the end of STOP, go directly to START: back-to-back frames with no idle gap, frame period 10*BAUD_DIV.
- Completion: when STOP ends with remaining=0, go to IDLE; done=1 and busy=0 on that same cycle.
- Total dump time is length*10*BAUD_DIV + RAM_LAT + 2 clocks from start to done.
- start while busy is ignored; no queueing.
- abort=1 in any non-IDLE state: on the next clock FSM=IDLE, uart_tx=1, busy=0, no done pulse. rd_addr holds its value.
  - A partial frame is truncated; the receiver sees a framing error, which is acceptable.
  - abort and start on the same cycle in IDLE: abort wins, start is ignored.
- start_addr, length and rd_data are don't-care outside their sampling points.
- uart_tx is driven from a register (glitch-free).

Test Plan:
1. Hold rst_n=0 mid-frame, then release -> uart_tx=1, busy=0, done=0, rd_addr=0 immediately; line stays idle with no start.
2. CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10), RAM[5]=0xA5, start_addr=5, length=1 -> uart_tx falls 3 clocks after start. Line sequence, each level held 10 clocks: 0 (start), data 1,0,1,0,0,1,0,1, then 1 (stop). done pulses at clock 103; busy is high for clocks 1..102.
3. RAM[0..2]=0x00,0xFF,0x55, length=3 -> three contiguous frames, with stop followed directly by the next start. rd_addr steps 0,1,2,3. done arrives 303 clocks after start.
4. start_addr=0x7FFF, length=2, RAM[0x7FFF]=0x12, RAM[0]=0x34 -> rd_addr goes 0x7FFF then 0x0000; the bytes sent are 0x12 then 0x34.
5. Assert abort during DATA bit 4 of the first byte -> uart_tx=1 and busy=0 one clock later, no done pulse. A fresh start 5 clocks later is accepted and transmits normally.
6. start with length=0 -> done pulse one clock later, busy never asserted, uart_tx stays 1. A second start pulsed while busy in scenario 2 has no effect on timing or data.

Source files
------------

// File: rtl/la_uart_tx_dump_if.sv
// Bundles the dump request/status handshake and the sample-RAM read port.
// The master side is the host plus sample RAM; the slave side is the dump engine.
interface la_uart_tx_dump_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (
        output start, start_addr, length, abort, rd_data,
        input  busy, done, rd_addr
    );

    modport slave (
        input  start, start_addr, length, abort, rd_data,
        output busy, done, rd_addr
    );
endinterface

// File: rtl/la_uart_tx_dump.sv
// Streams a captured logic-analyzer buffer from the sample RAM out of a UART
// TX line (8N1, LSB first). The next byte is prefetched during each stop bit,
// so multi-byte dumps go out back to back with no idle gap between frames.
module la_uart_tx_dump #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 15,
    parameter int RAM_LAT  = 1
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    la_uart_tx_dump_if.slave bus,
    output logic             uart_tx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int LAT_W    = $clog2(RAM_LAT + 2);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [7:0]        shift_q, shift_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end     = (baud_q == BAUD_LAST);
    assign bus.rd_addr = addr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign uart_tx     = tx_q;

    // Next-state and next-output logic; line level, busy and done are computed
    // one cycle ahead so they change on the same edge as the state they describe.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        lat_d       = lat_q;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        if (state_q != IDLE && bus.abort) begin
            state_d   = IDLE;
            baud_d    = '0;
            bit_idx_d = '0;
            lat_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (bus.length != '0) begin
                            addr_d      = bus.start_addr;
                            remaining_d = bus.length;
                            lat_d       = '0;
                            busy_d      = 1'b1;
                            state_d     = FETCH;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    busy_d  = 1'b1;
                    lat_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    busy_d = 1'b1;
                    if (lat_q == LAT_LAST) begin
                        shift_d = bus.rd_data;
                        baud_d  = '0;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                START: begin
                    busy_d = 1'b1;
                    tx_d   = 1'b0;
                    baud_d = baud_q + 1'b1;
                    if (bit_end) begin
                        baud_d    = '0;
                        bit_idx_d = '0;
                        tx_d      = shift_q[0];
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    busy_d = 1'b1;
                    tx_d   = shift_q[0];
                    baud_d = baud_q + 1'b1;
                    if (bit_end) begin
                        baud_d = '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_d        = 1'b1;
                            addr_d      = addr_q + 1'b1;
                            remaining_d = remaining_q - 1'b1;
                            state_d     = STOP;
                        end else begin
                            shift_d   = shift_q >> 1;
                            tx_d      = shift_q[1];
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    busy_d = 1'b1;
                    tx_d   = 1'b1;
                    baud_d = baud_q + 1'b1;
                    if (bit_end) begin
                        baud_d = '0;
                        if (remaining_q != '0) begin
                            shift_d = bus.rd_data;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; the line idles high out of reset.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            lat_q       <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            lat_q       <= lat_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_la_uart_tx_dump.sv
// Bench for la_uart_tx_dump: a sample RAM model feeds the dump engine and every
// dump is compared against a line waveform built from the 8N1 frame rules.
module tb_la_uart_tx_dump;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam int ADDR_W   = 15;
    localparam int RAM_LAT  = 1;
    localparam int LEAD     = RAM_LAT + 2;
    localparam int FRAME    = 10 * BD;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_tx;
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int checks = 0;
    int passes = 0;

    la_uart_tx_dump_if #(.ADDR_W(ADDR_W)) bus ();

    la_uart_tx_dump #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ADDR_W  (ADDR_W),
        .RAM_LAT (RAM_LAT)
    ) dut (
        .clk_50M(clk_50M),
        .rst_n  (rst_n),
        .bus    (bus),
        .uart_tx(uart_tx)
    );

    // Free-running clock.
    always #5 clk_50M = ~clk_50M;

    // Sample RAM with one clock of read latency.
    always @(posedge clk_50M) bus.rd_data <= mem[bus.rd_addr];

    // Safety net so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] sa,
                                 input logic [ADDR_W:0] len, input logic ab);
        bus.start      = s;
        bus.start_addr = sa;
        bus.length     = len;
        bus.abort      = ab;
    endtask

    // One dump: abort_at / stray_at are sample indices (-1 = unused), where
    // sample n is taken on the negedge after the n-th edge following the start edge.
    task automatic runDump(input string name, input logic [ADDR_W-1:0] saddr, input int len,
                           input int abort_at, input int stray_at);
        logic exp_wave[$];
        logic obs_tx[$];
        logic [ADDR_W-1:0] exp_addr[$];
        logic [ADDR_W-1:0] obs_addr[$];
        logic [7:0] b;
        logic [7:0] dec;
        logic exp_busy;
        int done_exp, window, stops, first_bad, obs_fall, obs_done, done_cnt, busy_bad, exp_fall;

        if (abort_at >= 0) begin
            done_exp = -1;
            window   = abort_at + 5;
        end else if (len == 0) begin
            done_exp = 0;
            window   = 8;
        end else begin
            done_exp = len * FRAME + LEAD;
            window   = done_exp + 6;
        end
        exp_fall = (len == 0) ? -1 : LEAD;

        for (int n = 0; n < LEAD; n++) exp_wave.push_back(1'b1);
        for (int k = 0; k < len; k++) begin
            b = mem[ADDR_W'(int'(saddr) + k)];
            for (int bitn = 0; bitn < 10; bitn++)
                for (int t = 0; t < BD; t++)
                    exp_wave.push_back(bitn == 0 ? 1'b0 : (bitn == 9 ? 1'b1 : b[bitn-1]));
        end
        while (exp_wave.size() < window) exp_wave.push_back(1'b1);
        if (abort_at >= 0)
            for (int n = abort_at + 1; n < exp_wave.size(); n++) exp_wave[n] = 1'b1;

        stops = 0;
        for (int k = 0; k < len; k++)
            if (abort_at < 0 || abort_at >= LEAD + k * FRAME + 9 * BD) stops++;
        for (int i = 0; i <= stops; i++) exp_addr.push_back(ADDR_W'(int'(saddr) + i));

        @(negedge clk_50M);
        applyStimulus(1'b1, saddr, (ADDR_W+1)'(len), 1'b0);
        @(negedge clk_50M);
        obs_done = -1;
        done_cnt = 0;
        busy_bad = 0;
        for (int n = 0; n < window; n++) begin
            obs_tx.push_back(uart_tx);
            if (n == 0) obs_addr.push_back(bus.rd_addr);
            else if (bus.rd_addr !== obs_addr[obs_addr.size()-1]) obs_addr.push_back(bus.rd_addr);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (obs_done < 0) obs_done = n;
            end
            if (len == 0) exp_busy = 1'b0;
            else if (abort_at >= 0) exp_busy = (n <= abort_at);
            else exp_busy = (n < done_exp);
            if ((n >= 1 || len == 0) && bus.busy !== exp_busy) busy_bad++;
            applyStimulus(n == stray_at, ADDR_W'($urandom), (ADDR_W+1)'($urandom), n == abort_at);
            @(negedge clk_50M);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);

        first_bad = -1;
        obs_fall  = -1;
        for (int n = 0; n < window; n++) begin
            if (obs_fall < 0 && obs_tx[n] === 1'b0) obs_fall = n;
            if (first_bad < 0 && obs_tx[n] !== exp_wave[n]) first_bad = n;
        end
        checkOutput({name, " fall"}, obs_fall, exp_fall);
        checkOutput({name, " line_first_bad"}, first_bad, -1);
        checkOutput({name, " done_at"}, obs_done, done_exp);
        checkOutput({name, " done_cnt"}, done_cnt, (done_exp >= 0) ? 1 : 0);
        checkOutput({name, " busy_bad"}, busy_bad, 0);
        if (abort_at < 0) begin
            for (int k = 0; k < len; k++) begin
                for (int j = 0; j < 8; j++)
                    dec[j] = obs_tx[LEAD + k * FRAME + (1 + j) * BD + BD / 2];
                checkOutput($sformatf("%s byte%0d", name, k), dec, mem[ADDR_W'(int'(saddr) + k)]);
            end
        end
        if (len != 0) begin
            checkOutput({name, " addr_cnt"}, obs_addr.size(), exp_addr.size());
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
                checkOutput($sformatf("%s addr%0d", name, i), obs_addr[i], exp_addr[i]);
        end
    endtask

    initial begin
        int bad;
        int len;
        int ab;
        int st;
        logic [ADDR_W-1:0] sa;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50M);
        checkOutput("reset tx", uart_tx, 1);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset rd_addr", bus.rd_addr, 0);
        rst_n = 1'b1;

        // Single byte, with a stray start while busy
        mem[5] = 8'hA5;
        runDump("single", 15'd5, 1, -1, 40);

        // Three back-to-back frames
        mem[0] = 8'h00;
        mem[1] = 8'hFF;
        mem[2] = 8'h55;
        runDump("triple", 15'd0, 3, -1, -1);

        // Address wrap
        mem[15'h7FFF] = 8'h12;
        mem[0]        = 8'h34;
        runDump("wrap", 15'h7FFF, 2, -1, -1);

        // Abort during data bit 4, then a fresh dump
        runDump("abort", ADDR_W'($urandom), 2, LEAD + 5 * BD + 2, -1);
        runDump("after_abort", ADDR_W'($urandom), 1, -1, -1);

        // Zero-length request
        runDump("zero_len", ADDR_W'($urandom), 0, -1, -1);

        // Abort and start together in IDLE: nothing happens
        @(negedge clk_50M);
        applyStimulus(1'b1, 15'd9, 16'd3, 1'b1);
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_50M);
            applyStimulus(1'b0, '0, '0, 1'b0);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || uart_tx !== 1'b1) bad++;
        end
        checkOutput("abort_start_idle bad", bad, 0);

        // Randomized dumps, some aborted, some with stray starts
        for (int r = 0; r < 6; r++) begin
            sa  = ($urandom_range(0, 2) == 0) ? 15'h7FFE : ADDR_W'($urandom);
            len = $urandom_range(1, 3);
            ab  = -1;
            st  = -1;
            if ($urandom_range(0, 2) == 0) ab = $urandom_range(LEAD, len * FRAME + LEAD - 2);
            else st = $urandom_range(0, len * FRAME + LEAD - 2);
            runDump($sformatf("rand%0d", r), sa, len, ab, st);
        end

        // Reset asserted in the middle of a frame
        @(negedge clk_50M);
        applyStimulus(1'b1, 15'h0123, 16'd2, 1'b0);
        @(negedge clk_50M);
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (50) @(negedge clk_50M);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset tx", uart_tx, 1);
        checkOutput("midreset busy", bus.busy, 0);
        checkOutput("midreset done", bus.done, 0);
        checkOutput("midreset rd_addr", bus.rd_addr, 0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_50M);
            if (uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checkOutput("post_reset idle bad", bad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
